regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the single register-file write port. It accepts write requests from two pipeline sources, the ALU/EX path (port A) and the load/MEM path (port B), and buffers one entry per source. It serialises the buffered entries onto the port's RegWrite / WriteRegister / WriteData signals, which feed the 5:32 write-enable decoder and the register array. It also exports a pending-write mask for hazard and forwarding logic.

## Interface
Parameters:
- DATA_WIDTH, 64, register data width
- ZR_INDEX, 31, zero-register index; writes to it are discarded

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a_valid  input  1  port A request valid
- a_ready  output  1  port A can accept this cycle
- a_reg  input  5  port A destination register
- a_data  input  DATA_WIDTH  port A write data
- b_valid, b_ready, b_reg, b_data  same as A, for port B
- RegWrite  output  1  register-file write enable (registered)
- WriteRegister  output  5  destination register (registered)
- WriteData  output  DATA_WIDTH  write data (registered)
- pending  output  32  one-hot OR of destination registers currently held, not yet written

## Operation
- Each port has one hold slot containing valid, reg, data, and a capture-order tag.
- Ready rule:
  - x_ready = ~hold_valid_x | grant_x.
  - grant_x is computed from the current slot state only, never from x_valid. This keeps the loop combinational-free.
- Accept on x_valid & x_ready at a clock edge:
  - If x_reg == ZR_INDEX, the request is consumed (handshake completes) and nothing is stored.
  - Otherwise the slot is loaded.
- Grant, evaluated each cycle:
  - Only one slot valid: grant that slot.
  - Both valid, same reg: grant the older slot (earlier capture). If both were captured on the same edge, grant B, since MEM holds the older instruction.
  - Both valid, different reg: round-robin. Grant the port not granted last; the last-grant pointer updates on every grant.
- On the edge after a grant:
  - RegWrite <= 1, and WriteRegister / WriteData <= the granted slot's contents.
  - The slot clears, unless the same port is accepting a new request on that edge, in which case the slot reloads.
- With no grant, RegWrite <= 0 on the next edge. WriteRegister and WriteData hold their values.
- pending[r] = (holdA_valid & holdA_reg==r) | (holdB_valid & holdB_reg==r). It is combinational from slot state. Bit 31 is never set.

## Timing
- Reset (asynchronous) clears:
  - both slots
  - RegWrite=0, WriteRegister=0, WriteData=0
  - pending=0
  - last-grant pointer = B, so A wins the first round-robin tie
- Reset asserted mid-operation drops held entries; no partial write is issued.
- Latency: accept at edge N → grant during cycle N..N+1 → RegWrite high for exactly one cycle after edge N+1.
- Throughput:
  - One write per cycle total.
  - A single active port sustains back-to-back accepts (1 per cycle).
  - Two active ports each get 1 per 2 cycles under contention.
- Backpressure: x_ready low means the slot is full and not granted this cycle. The requester must hold valid, reg and data stable until accepted.
- Starvation bound: a held entry is written within 2 cycles of capture.

## Structure
- Shared package regfile_pkg holds:
  - NUM_REGS=32
  - REG_ZR=5'd31
  - typedef wb_req_t {reg[4:0], data[DATA_WIDTH-1:0]}
- Sub-module wb_hold_slot, instantiated twice: one-entry slot with valid, load/clear, and capture-order tag.
- The arbiter top contains the grant logic, round-robin pointer, output registers and pending-mask generation.

## Test plan
- Reset behaviour: assert reset asynchronously mid-cycle with both slots full. Required response: RegWrite=0, pending=0, a_ready=b_ready=1 immediately, and no write after release.
- Single port stream: A sends reg 1,2,3 with data 0x11,0x22,0x33 on consecutive cycles. Required response: RegWrite high for 3 consecutive cycles with WriteRegister 1,2,3 and matching data, and a_ready held at 1.
- Contention: A and B both valid continuously after reset, A reg 5 and B reg 7. Required response: writes alternate 5,7,5,7; each ready toggles every cycle.
- Same-register ordering: A and B both capture reg 9 on the same edge, B data 0xB, A data 0xA. Required response: write 9=0xB, then 9=0xA, and pending[9] stays high until the second write.
- Zero register: B sends reg 31. Required response: b_ready=1, no RegWrite, pending stays 0. A concurrent A request to reg 4 is written 1 cycle later, with no gap.
- Backpressure hold: fill both slots and keep A valid. Required response: a_ready=0 until A's slot is granted, and the new A data is captured on that same edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

    localparam int NUM_REGS      = 32;
    localparam int REG_IDX_W     = 5;
    localparam int WB_DATA_WIDTH = 64;
    localparam int WB_TAG_W      = 2;

    localparam logic [REG_IDX_W-1:0] REG_ZR = 5'd31;

    typedef struct packed {
        logic [REG_IDX_W-1:0]     rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry write-back hold slot with a capture-order tag.
module wb_hold_slot
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [REG_IDX_W-1:0]  new_rd,
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [WB_TAG_W-1:0]   new_tag,
    output logic                  valid,
    output logic [REG_IDX_W-1:0]  rd,
    output logic [DATA_WIDTH-1:0] data,
    output logic [WB_TAG_W-1:0]   tag
);

    // Load wins over clear so a granted slot can refill on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            rd    <= '0;
            data  <= '0;
            tag   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            rd    <= new_rd;
            data  <= new_data;
            tag   <= new_tag;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source write-back arbiter for the single register-file write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int                   DATA_WIDTH = 64,
    parameter logic [REG_IDX_W-1:0] ZR_INDEX   = REG_ZR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_IDX_W-1:0]  a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_IDX_W-1:0]  b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  RegWrite,
    output logic [REG_IDX_W-1:0]  WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic [NUM_REGS-1:0]   pending
);

    logic                  a_held;
    logic                  b_held;
    logic [REG_IDX_W-1:0]  a_rd;
    logic [REG_IDX_W-1:0]  b_rd;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [WB_TAG_W-1:0]   a_tag;
    logic [WB_TAG_W-1:0]   b_tag;
    logic [WB_TAG_W-1:0]   a_age;
    logic [WB_TAG_W-1:0]   b_age;
    logic [WB_TAG_W-1:0]   cyc;
    logic                  last_a;
    logic                  grant_a;
    logic                  grant_b;
    logic                  a_load;
    logic                  b_load;
    logic                  same_rd;
    logic                  a_older;

    // Entries live at most two cycles, so a wrapping stamp orders them.
    assign a_age   = cyc - a_tag;
    assign b_age   = cyc - b_tag;
    assign same_rd = a_rd == b_rd;
    assign a_older = a_age > b_age;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (1'b1)
            a_held & ~b_held: grant_a = 1'b1;
            ~a_held & b_held: grant_b = 1'b1;
            a_held & b_held & same_rd: begin
                grant_a = a_older;
                grant_b = ~a_older;
            end
            a_held & b_held & ~same_rd: begin
                grant_a = ~last_a;
                grant_b = last_a;
            end
            default: ;
        endcase
    end

    assign a_ready = ~a_held | grant_a;
    assign b_ready = ~b_held | grant_b;

    // Zero-register requests complete the handshake but are never stored.
    assign a_load = a_valid & a_ready & (a_reg != ZR_INDEX);
    assign b_load = b_valid & b_ready & (b_reg != ZR_INDEX);

    wb_hold_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clk      (clk),
        .reset    (reset),
        .load     (a_load),
        .clear    (grant_a),
        .new_rd   (a_reg),
        .new_data (a_data),
        .new_tag  (cyc),
        .valid    (a_held),
        .rd       (a_rd),
        .data     (a_q),
        .tag      (a_tag)
    );

    wb_hold_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
        .clk      (clk),
        .reset    (reset),
        .load     (b_load),
        .clear    (grant_b),
        .new_rd   (b_reg),
        .new_data (b_data),
        .new_tag  (cyc),
        .valid    (b_held),
        .rd       (b_rd),
        .data     (b_q),
        .tag      (b_tag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc           <= '0;
            last_a        <= 1'b0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            cyc      <= cyc + 1'b1;
            RegWrite <= grant_a | grant_b;
            if (grant_a) begin
                WriteRegister <= a_rd;
                WriteData     <= a_q;
                last_a        <= 1'b1;
            end else if (grant_b) begin
                WriteRegister <= b_rd;
                WriteData     <= b_q;
                last_a        <= 1'b0;
            end
        end
    end

    always_comb begin
        pending = '0;
        if (a_held) pending[a_rd] = 1'b1;
        if (b_held) pending[b_rd] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// cycle-stamped reference model of the two hold slots.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid;
    logic          a_ready;
    logic [4:0]    a_reg;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_reg;
    logic [DW-1:0] b_data;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [DW-1:0] WriteData;
    logic [31:0]   pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ZR_INDEX(5'd31)) dut (
        .clk           (clk),
        .reset         (reset),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_reg         (a_reg),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_reg         (b_reg),
        .b_data        (b_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .pending       (pending)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit      v;
        wb_req_t req;
        int      cap;
    } held_t;

    held_t   ha;
    held_t   hb;
    bit      last_was_a;
    bit      exp_we;
    wb_req_t out_w;
    int      cyc = 0;

    function automatic void model_reset();
        ha.v       = 0;
        hb.v       = 0;
        last_was_a = 0;
        exp_we     = 0;
        out_w      = '0;
    endfunction

    // 0 none, 1 port A, 2 port B
    function automatic int pick();
        if (ha.v && hb.v) begin
            if (ha.req.rd == hb.req.rd) return (ha.cap < hb.cap) ? 1 : 2;
            return last_was_a ? 2 : 1;
        end
        if (ha.v) return 1;
        if (hb.v) return 2;
        return 0;
    endfunction

    task automatic tick(output bit acc_a, output bit acc_b);
        int          g;
        logic [31:0] m;
        bit          ra;
        bit          rb;
        g  = pick();
        ra = !ha.v || g == 1;
        rb = !hb.v || g == 2;
        m  = '0;
        if (ha.v) m[ha.req.rd] = 1'b1;
        if (hb.v) m[hb.req.rd] = 1'b1;
        check("regwrite", RegWrite, exp_we);
        check("wreg", WriteRegister, out_w.rd);
        check("wdata", WriteData, out_w.data);
        check("pending", pending, m);
        check("a_ready", a_ready, ra);
        check("b_ready", b_ready, rb);
        acc_a  = a_valid && ra;
        acc_b  = b_valid && rb;
        exp_we = g != 0;
        if (g == 1) begin
            out_w = ha.req; ha.v = 0; last_was_a = 1;
        end
        if (g == 2) begin
            out_w = hb.req; hb.v = 0; last_was_a = 0;
        end
        if (acc_a && a_reg != REG_ZR) begin
            ha.v = 1; ha.req.rd = a_reg; ha.req.data = a_data; ha.cap = cyc;
        end
        if (acc_b && b_reg != REG_ZR) begin
            hb.v = 1; hb.req.rd = b_reg; hb.req.data = b_data; hb.cap = cyc;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit av, input logic [4:0] ar, input logic [63:0] ad,
                         input bit bv, input logic [4:0] br, input logic [63:0] bd);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    task automatic idle(input int n);
        bit x;
        bit y;
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        for (int i = 0; i < n; i++) tick(x, y);
    endtask

    task automatic do_reset();
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    function automatic logic [4:0] rand_reg();
        if ($urandom_range(0, 5) == 0) return REG_ZR;
        return 5'($urandom_range(0, 7));
    endfunction

    bit          acc_a;
    bit          acc_b;
    bit          pa;
    bit          pb;
    bit          got_it;

    initial begin
        reset = 1'b1;
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        model_reset();
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_pending", pending, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // single-port stream
        drive(1, 5'd1, 64'h11, 0, 5'd0, 64'd0); tick(acc_a, acc_b);
        drive(1, 5'd2, 64'h22, 0, 5'd0, 64'd0); tick(acc_a, acc_b);
        drive(1, 5'd3, 64'h33, 0, 5'd0, 64'd0); tick(acc_a, acc_b);
        idle(3);

        // contention, distinct registers
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'd5, 64'(i + 16'hA0), 1, 5'd7, 64'(i + 16'hB0));
            tick(acc_a, acc_b);
        end
        idle(3);

        // same register captured on one edge: B drains first
        drive(1, 5'd9, 64'hA, 1, 5'd9, 64'hB); tick(acc_a, acc_b);
        idle(3);

        // zero register on B alongside A
        drive(1, 5'd4, 64'h44, 1, 5'd31, 64'hDEAD); tick(acc_a, acc_b);
        idle(3);

        // backpressure on A with both slots full
        drive(1, 5'd2, 64'h200, 1, 5'd3, 64'h300); tick(acc_a, acc_b);
        drive(1, 5'd12, 64'hC0C0, 0, 5'd0, 64'd0);
        got_it = 0;
        for (int i = 0; i < 5 && !got_it; i++) begin
            tick(acc_a, acc_b);
            got_it = acc_a;
        end
        check("bp_accept", got_it, 1);
        idle(3);

        // asynchronous reset mid-cycle with both slots full
        drive(1, 5'd3, 64'h3, 1, 5'd6, 64'h6); tick(acc_a, acc_b);
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_regwrite", RegWrite, 0);
        check("arst_pending", pending, 0);
        check("arst_a_ready", a_ready, 1);
        check("arst_b_ready", b_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        // randomized traffic; requesters hold until accepted
        pa = 0;
        pb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1; a_reg = rand_reg(); a_data = {$urandom, $urandom};
            end
            if (!pb && $urandom_range(0, 3) != 0) begin
                pb = 1; b_reg = rand_reg(); b_data = {$urandom, $urandom};
            end
            a_valid = pa;
            b_valid = pb;
            tick(acc_a, acc_b);
            if (acc_a) pa = 0;
            if (acc_b) pb = 0;
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
